// File: rtl/gyruss_irq_gen.sv
// gyruss_irq_gen: multi-channel raster interrupt generator.
// Each channel counts vertical-line events, either any line change or a
// compare-line match. A channel sets PEND when its event divider expires.
// The host programs and acknowledges channels through a byte-wide register port.
module gyruss_irq_gen #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned VW   = 9,
    parameter int unsigned DIVW = 4,
    parameter int unsigned AW   = $clog2(NCH) + 2
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    input  logic          CE,
    input  logic [VW-1:0] PV,
    input  logic          REG_WE,
    input  logic [AW-1:0] REG_AD,
    input  logic [7:0]    REG_WD,
    output logic [7:0]    REG_RD,
    output logic          IRQ,
    output logic [2:0]    IRQ_VEC
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CMP    = 2'd1;
    localparam logic [1:0] REG_ACK    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // current state
    logic [NCH-1:0]  en, mode, pend;
    logic [DIVW-1:0] div [NCH];
    logic [DIVW-1:0] cnt [NCH];
    logic [7:0]      cmp [NCH];
    logic [VW-1:0]   ppv;

    // next state
    logic [NCH-1:0]  en_n, mode_n, pend_n;
    logic [DIVW-1:0] div_n [NCH];
    logic [DIVW-1:0] cnt_n [NCH];
    logic [7:0]      cmp_n [NCH];
    logic [VW-1:0]   ppv_n;

    logic [AW-1:0]   ch_sel;
    logic [1:0]      reg_sel;
    logic            lev;
    logic [7:0]      pv_lo;
    logic [DIVW-1:0] wd_div;

    assign ch_sel  = REG_AD >> 2;
    assign reg_sel = REG_AD[1:0];
    assign lev     = (PV != ppv);
    assign pv_lo   = 8'(PV);
    assign wd_div  = REG_WD[4 +: DIVW];

    // Next-state: line event, per-channel divider, then register writes on top.
    always_comb begin
        ppv_n  = ppv;
        en_n   = en;
        mode_n = mode;
        pend_n = pend;
        for (int i = 0; i < NCH; i++) begin
            div_n[i] = div[i];
            cnt_n[i] = cnt[i];
            cmp_n[i] = cmp[i];
        end

        if (lev) begin
            ppv_n = PV;
        end

        for (int i = 0; i < NCH; i++) begin
            logic ev;
            logic fire;
            logic hit;
            ev   = lev && (!mode[i] || (pv_lo == cmp[i]));
            fire = ev && (cnt[i] == div[i]);
            hit  = REG_WE && (ch_sel == AW'(i));

            // event uses the old field values
            if (ev) begin
                cnt_n[i] = fire ? '0 : cnt[i] + DIVW'(1);
                if (fire && en[i]) begin
                    pend_n[i] = 1'b1;
                end
            end

            if (hit) begin
                unique case (reg_sel)
                    REG_CTRL: begin
                        en_n[i]   = REG_WD[0];
                        mode_n[i] = REG_WD[1];
                        div_n[i]  = wd_div;
                        if (!REG_WD[0]) begin
                            // disabling write overrides any same-edge event
                            pend_n[i] = 1'b0;
                            cnt_n[i]  = '0;
                        end else if (wd_div != div[i]) begin
                            cnt_n[i] = '0;
                        end
                    end
                    REG_CMP: cmp_n[i] = REG_WD;
                    // a fire on the same edge keeps the interrupt alive
                    REG_ACK: pend_n[i] = fire && en[i];
                    REG_STATUS: ;
                    default: ;
                endcase
            end
        end
    end

    // State register; all updates qualified by CE.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ppv  <= '0;
            en   <= '0;
            mode <= '0;
            pend <= '0;
            for (int i = 0; i < NCH; i++) begin
                div[i] <= '0;
                cnt[i] <= '0;
                cmp[i] <= '0;
            end
        end else if (CE) begin
            ppv  <= ppv_n;
            en   <= en_n;
            mode <= mode_n;
            pend <= pend_n;
            for (int i = 0; i < NCH; i++) begin
                div[i] <= div_n[i];
                cnt[i] <= cnt_n[i];
                cmp[i] <= cmp_n[i];
            end
        end
    end

    // Read mux; unimplemented channels read as zero.
    always_comb begin
        REG_RD = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == AW'(i)) begin
                unique case (reg_sel)
                    REG_CTRL: begin
                        REG_RD[0]         = en[i];
                        REG_RD[1]         = mode[i];
                        REG_RD[4 +: DIVW] = div[i];
                    end
                    REG_CMP: REG_RD = cmp[i];
                    REG_STATUS: begin
                        REG_RD[0]         = pend[i];
                        REG_RD[1]         = en[i];
                        REG_RD[4 +: DIVW] = cnt[i];
                    end
                    default: REG_RD = '0;
                endcase
            end
        end
    end

    // IRQ and priority vector; channel 0 has the highest priority.
    always_comb begin
        IRQ     = 1'b0;
        IRQ_VEC = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i] && en[i]) begin
                IRQ     = 1'b1;
                IRQ_VEC = 3'(i);
            end
        end
    end

endmodule

// File: tb/tb_gyruss_irq_gen.sv
// Self-checking bench for gyruss_irq_gen (NCH=4, VW=9, DIVW=4).
module tb_gyruss_irq_gen;

    localparam int unsigned AW = 4;

    logic       MCLK = 1'b0;
    logic       RESET_N;
    logic       CE;
    logic [8:0] PV;
    logic       REG_WE;
    logic [3:0] REG_AD;
    logic [7:0] REG_WD;
    logic [7:0] REG_RD;
    logic       IRQ;
    logic [2:0] IRQ_VEC;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] e;
    logic [7:0] rdv;

    gyruss_irq_gen #(.NCH(4), .VW(9), .DIVW(4), .AW(AW)) dut (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .CE      (CE),
        .PV      (PV),
        .REG_WE  (REG_WE),
        .REG_AD  (REG_AD),
        .REG_WD  (REG_WD),
        .REG_RD  (REG_RD),
        .IRQ     (IRQ),
        .IRQ_VEC (IRQ_VEC)
    );

    always #5 MCLK = ~MCLK;

    function automatic logic [3:0] ad(input int ch, input int r);
        return 4'((ch << 2) | r);
    endfunction

    // one CE edge with a register write
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge MCLK);
        CE = 1'b1; REG_WE = 1'b1; REG_AD = a; REG_WD = d;
        @(posedge MCLK); #1;
        REG_WE = 1'b0;
    endtask

    // one CE edge with a new PV value
    task automatic pv_step(input logic [8:0] v);
        @(negedge MCLK);
        CE = 1'b1; PV = v;
        @(posedge MCLK); #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        REG_AD = a; #1;
        d = REG_RD;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; CE = 1'b0; PV = '0; REG_WE = 1'b0; REG_AD = '0; REG_WD = '0;
        repeat (2) @(posedge MCLK);
        @(negedge MCLK); RESET_N = 1'b1;
        @(posedge MCLK); #1;
        exp_q.push_back(8'h00);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL reset_irq got=%0h exp=%0h", IRQ, e); end
        exp_q.push_back(8'h00);
        e = exp_q.pop_front(); checks++;
        if ({5'd0, IRQ_VEC} !== e) begin failures++; $display("FAIL reset_vec got=%0h exp=%0h", IRQ_VEC, e); end
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(8'h00);
            rd(ad(0, r), rdv);
            e = exp_q.pop_front(); checks++;
            if (rdv !== e) begin failures++; $display("FAIL reset_reg%0d got=%0h exp=%0h", r, rdv, e); end
        end
    endtask

    task automatic test_basic;
        wr(ad(0, 0), 8'h01);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
        pv_step(9'd1);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL basic_irq got=%0h exp=%0h", IRQ, e); end
        e = exp_q.pop_front(); checks++;
        if ({5'd0, IRQ_VEC} !== e) begin failures++; $display("FAIL basic_vec got=%0h exp=%0h", IRQ_VEC, e); end
        rd(ad(0, 3), rdv);
        e = exp_q.pop_front(); checks++;
        if (rdv !== e) begin failures++; $display("FAIL basic_status got=%0h exp=%0h", rdv, e); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        wr(ad(0, 2), 8'hff);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL ack_irq got=%0h exp=%0h", IRQ, e); end
        rd(ad(0, 3), rdv);
        e = exp_q.pop_front(); checks++;
        if (rdv !== e) begin failures++; $display("FAIL ack_status got=%0h exp=%0h", rdv, e); end
    endtask

    task automatic test_divider;
        wr(ad(0, 0), 8'h31);
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = k % 4;
            exp_q.push_back((c == 0) ? 8'h01 : 8'h00);
            exp_q.push_back((c == 0) ? 8'h03 : 8'((c << 4) | 2));
            pv_step(9'(k + 1));
            e = exp_q.pop_front(); checks++;
            if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL div_irq k=%0d got=%0h exp=%0h", k, IRQ, e); end
            rd(ad(0, 3), rdv);
            e = exp_q.pop_front(); checks++;
            if (rdv !== e) begin failures++; $display("FAIL div_status k=%0d got=%0h exp=%0h", k, rdv, e); end
            if (c == 0) wr(ad(0, 2), 8'h00);
        end
        wr(ad(0, 0), 8'h00);
    endtask

    task automatic test_compare;
        int fires;
        fires = 0;
        wr(ad(1, 0), 8'h03);
        wr(ad(1, 1), 8'h10);
        for (int p = 0; p <= 32; p++) begin
            exp_q.push_back((p == 16) ? 8'h01 : 8'h00);
            pv_step(9'(p));
            e = exp_q.pop_front(); checks++;
            if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL cmp_irq pv=%0h got=%0h exp=%0h", p, IRQ, e); end
            if (IRQ) begin
                fires++;
                exp_q.push_back(8'h01);
                e = exp_q.pop_front(); checks++;
                if ({5'd0, IRQ_VEC} !== e) begin failures++; $display("FAIL cmp_vec got=%0h exp=%0h", IRQ_VEC, e); end
                wr(ad(1, 2), 8'h00);
            end
        end
        exp_q.push_back(8'h01);
        e = exp_q.pop_front(); checks++;
        if (8'(fires) !== e) begin failures++; $display("FAIL cmp_fires got=%0d exp=%0d", fires, e); end
        exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        pv_step(9'h110);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL cmp_hi_irq got=%0h exp=%0h", IRQ, e); end
        e = exp_q.pop_front(); checks++;
        if ({5'd0, IRQ_VEC} !== e) begin failures++; $display("FAIL cmp_hi_vec got=%0h exp=%0h", IRQ_VEC, e); end
        wr(ad(1, 2), 8'h00);
    endtask

    task automatic test_ack_race;
        wr(ad(0, 0), 8'h01);
        pv_step(9'h111);
        exp_q.push_back(8'h01); exp_q.push_back(8'h03);
        @(negedge MCLK);
        CE = 1'b1; REG_WE = 1'b1; REG_AD = ad(0, 2); REG_WD = 8'h00; PV = 9'h112;
        @(posedge MCLK); #1; REG_WE = 1'b0;
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL race_ack_irq got=%0h exp=%0h", IRQ, e); end
        rd(ad(0, 3), rdv);
        e = exp_q.pop_front(); checks++;
        if (rdv !== e) begin failures++; $display("FAIL race_ack_status got=%0h exp=%0h", rdv, e); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        @(negedge MCLK);
        CE = 1'b1; REG_WE = 1'b1; REG_AD = ad(0, 0); REG_WD = 8'h00; PV = 9'h113;
        @(posedge MCLK); #1; REG_WE = 1'b0;
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL race_dis_irq got=%0h exp=%0h", IRQ, e); end
        rd(ad(0, 3), rdv);
        e = exp_q.pop_front(); checks++;
        if (rdv !== e) begin failures++; $display("FAIL race_dis_status got=%0h exp=%0h", rdv, e); end
    endtask

    task automatic test_priority;
        wr(ad(1, 1), 8'h40);
        wr(ad(2, 0), 8'h03);
        wr(ad(2, 1), 8'h40);
        exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        pv_step(9'h040);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL prio_irq got=%0h exp=%0h", IRQ, e); end
        e = exp_q.pop_front(); checks++;
        if ({5'd0, IRQ_VEC} !== e) begin failures++; $display("FAIL prio_vec got=%0h exp=%0h", IRQ_VEC, e); end
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        wr(ad(1, 2), 8'h00);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL prio_ack1_irq got=%0h exp=%0h", IRQ, e); end
        e = exp_q.pop_front(); checks++;
        if ({5'd0, IRQ_VEC} !== e) begin failures++; $display("FAIL prio_ack1_vec got=%0h exp=%0h", IRQ_VEC, e); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        wr(ad(2, 2), 8'h00);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL prio_ack2_irq got=%0h exp=%0h", IRQ, e); end
        e = exp_q.pop_front(); checks++;
        if ({5'd0, IRQ_VEC} !== e) begin failures++; $display("FAIL prio_ack2_vec got=%0h exp=%0h", IRQ_VEC, e); end
    endtask

    task automatic test_ce_hold;
        wr(ad(0, 0), 8'h01);
        pv_step(9'd5);
        wr(ad(0, 2), 8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        @(negedge MCLK); CE = 1'b0; PV = 9'd6;
        @(negedge MCLK); PV = 9'd5;
        @(negedge MCLK); CE = 1'b1;
        @(posedge MCLK); #1;
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL ce_irq got=%0h exp=%0h", IRQ, e); end
        rd(ad(0, 3), rdv);
        e = exp_q.pop_front(); checks++;
        if (rdv !== e) begin failures++; $display("FAIL ce_status got=%0h exp=%0h", rdv, e); end
    endtask

    task automatic test_async_reset;
        exp_q.push_back(8'h01);
        pv_step(9'd7);
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL ares_pre_irq got=%0h exp=%0h", IRQ, e); end
        exp_q.push_back(8'h00);
        #1 RESET_N = 1'b0;
        #1;
        e = exp_q.pop_front(); checks++;
        if ({7'd0, IRQ} !== e) begin failures++; $display("FAIL ares_irq got=%0h exp=%0h", IRQ, e); end
        @(negedge MCLK); RESET_N = 1'b1;
        @(posedge MCLK); #1;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                exp_q.push_back(8'h00);
                rd(ad(ch, r), rdv);
                e = exp_q.pop_front(); checks++;
                if (rdv !== e) begin failures++; $display("FAIL ares_reg ch=%0d r=%0d got=%0h exp=%0h", ch, r, rdv, e); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_divider;
        test_compare;
        test_ack_race;
        test_priority;
        test_ce_hold;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
